// File: rtl/posit_add_scheduler.sv
// posit_add_scheduler
// Shares one fixed-latency posit adder among NUM_REQ requesters. A
// round-robin arbiter issues at most one operation per cycle, each requester
// may have only one operation outstanding, and a shadow pipeline carries the
// requester tag alongside the adder so that every sum lands in the response
// slot of the requester that issued it. Sums are opaque bit patterns.

module posit_add_scheduler #(
    parameter int WIDTH   = 7,
    parameter int NUM_REQ = 4,
    parameter int LAT     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       add_valid,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_result,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [NUM_REQ*WIDTH-1:0]   resp_data,
    output logic                       idle,
    output logic [15:0]                op_count
);

    localparam int TW = $clog2(NUM_REQ);

    logic [TW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] inflight;
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] elig;
    logic [LAT-1:0]     shadow_v;
    logic [TW-1:0]      shadow_tag [LAT];

    logic               grant_found;
    logic [TW-1:0]      grant_idx;
    logic [TW-1:0]      scan_idx;
    logic [TW-1:0]      next_ptr;
    logic               comp_v;
    logic [TW-1:0]      comp_tag;

    // A requester holding an op in flight or an unconsumed result may not
    // issue again; both terms are registered, so there is no bypass.
    assign busy = inflight | resp_valid;
    assign elig = req_valid & ~busy;

    // The last shadow stage lines up with add_result for the op it tracks.
    assign comp_v   = shadow_v[LAT-1];
    assign comp_tag = shadow_tag[LAT-1];

    assign idle = ~|inflight & ~|resp_valid & ~|shadow_v;

    // Round-robin search: first eligible index starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = TW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && elig[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // One-hot grant plus the operand mux feeding the shared adder.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && grant_idx == TW'(i)) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*WIDTH +: WIDTH];
                add_b        = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign add_valid = grant_found;

    // Pointer moves to the slot just after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx == TW'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + TW'(1);
        end
    end

    // Arbitration pointer and the tag pipeline that shadows the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            shadow_v <= '0;
            for (int s = 0; s < LAT; s++) begin
                shadow_tag[s] <= '0;
            end
        end else begin
            if (grant_found) begin
                rr_ptr <= next_ptr;
            end
            shadow_v[0]   <= grant_found;
            shadow_tag[0] <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                shadow_v[s]   <= shadow_v[s-1];
                shadow_tag[s] <= shadow_tag[s-1];
            end
        end
    end

    // Per-requester bookkeeping: issue marks in flight, completion fills the
    // response slot, and the response handshake frees the slot again.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_found && grant_idx == TW'(i)) begin
                    inflight[i] <= 1'b1;
                end else if (comp_v && comp_tag == TW'(i)) begin
                    inflight[i] <= 1'b0;
                end
                if (comp_v && comp_tag == TW'(i)) begin
                    resp_valid[i]               <= 1'b1;
                    resp_data[i*WIDTH +: WIDTH] <= add_result;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Completed-operation counter that sticks at its maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (comp_v && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
